cpu_run_ctrl: RTL and testbench



---
 rtl/cpu_run_ctrl_pkg.sv | 19 +
 rtl/cpu_run_ctrl_if.sv | 22 ++
 rtl/cpu_run_ctrl_mem_port_mux.sv | 22 ++
 rtl/cpu_run_ctrl.sv | 120 ++++++++++++
 tb/tb_cpu_run_ctrl.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control block: run-state encoding,
// default bus widths and the CPU fetch-state code.
package cpu_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    HALTED = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    DBG    = 2'd3
  } run_state_t;

  // CPU FSM fetch state; instr_start is asserted while the CPU sits here.
  localparam logic [3:0] CYCLE1 = 4'b0000;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Debug/loader access port. The requester holds dbg_req until dbg_done.
interface cpu_run_ctrl_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_done;

  modport master (
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_done
  );

  modport slave (
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_done
  );
endinterface

// File: rtl/cpu_run_ctrl_mem_port_mux.sv
// Shared memory port select: debug owns the port only in DBG, otherwise the
// CPU does, with its writes suppressed while the CPU is frozen.
module mem_port_mux #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          sel_dbg,
  input  logic          cpu_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we
);
  assign mem_addr  = sel_dbg ? dbg_addr  : cpu_addr;
  assign mem_wdata = sel_dbg ? dbg_wdata : cpu_wdata;
  assign mem_we    = sel_dbg ? dbg_we    : (cpu_we & cpu_en);
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control and memory-port arbiter for the multicycle CPU. Halts, resumes
// and single-steps only on fetch boundaries; one PC breakpoint; grants the
// memory port to the debug requester while halted.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          CLOCK_50,
  input  logic          RESETn,
  input  logic          run_req,
  input  logic          halt_req,
  input  logic          step_req,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  input  logic          instr_start,
  output logic          cpu_en,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_rdata,
  cpu_run_ctrl_if.slave dbg,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          halted,
  output logic          bp_hit,
  output logic [CW-1:0] instr_count
);

  run_state_t state;
  logic       first;      // no boundary executed yet since leaving HALTED
  logic       halt_pend;  // halt requested, waiting for the next boundary
  logic       bp_match;
  logic       stop;

  // first masks the breakpoint so resuming at bp_addr does not re-hit it
  assign bp_match = bp_en && (pc == bp_addr) && !first;

  // Stop condition evaluated at a boundary for the current run mode
  always_comb begin
    stop = 1'b0;
    case (state)
      RUN:     stop = halt_pend | ~run_req | bp_match;
      STEP:    stop = ~first;
      default: stop = 1'b0;
    endcase
  end

  assign cpu_en    = ((state == RUN) || (state == STEP)) && !(instr_start && stop);
  assign halted    = (state == HALTED);
  assign cpu_rdata = mem_rdata;

  mem_port_mux #(.AW(AW), .DW(DW)) u_mux (
    .sel_dbg   (state == DBG),
    .cpu_en    (cpu_en),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .dbg_addr  (dbg.dbg_addr),
    .dbg_wdata (dbg.dbg_wdata),
    .dbg_we    (dbg.dbg_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  // Run-state FSM with its sticky flags, debug access completion and counter
  always_ff @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      state         <= HALTED;
      first         <= 1'b0;
      halt_pend     <= 1'b0;
      bp_hit        <= 1'b0;
      dbg.dbg_done  <= 1'b0;
      dbg.dbg_rdata <= '0;
      instr_count   <= '0;
    end else begin
      dbg.dbg_done <= 1'b0;
      if (instr_start && cpu_en) instr_count <= instr_count + CW'(1);
      case (state)
        HALTED: begin
          if (dbg.dbg_req) begin
            state <= DBG;
          end else if (halt_req) begin
            // already halted: nothing to do
          end else if (step_req) begin
            state  <= STEP;
            first  <= 1'b1;
            bp_hit <= 1'b0;
          end else if (run_req) begin
            state  <= RUN;
            first  <= 1'b1;
            bp_hit <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (halt_req) halt_pend <= 1'b1;
          if (instr_start && cpu_en) first <= 1'b0;
          if (instr_start && stop) begin
            state     <= HALTED;
            halt_pend <= 1'b0;
            if ((state == RUN) && bp_match) bp_hit <= 1'b1;
          end
        end
        DBG: begin
          state        <= HALTED;
          dbg.dbg_done <= 1'b1;
          if (!dbg.dbg_we) dbg.dbg_rdata <= mem_rdata;
        end
        default: state <= HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a small 3-cycle CPU model and a 256-byte memory
// around the DUT; debug accesses are checked through a scoreboard queue.
module tb_cpu_run_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       RESETn   = 1'b1;
  logic       run_req = 0, halt_req = 0, step_req = 0, bp_en = 0;
  logic [7:0] bp_addr = 0;
  logic [7:0] pc, cpu_addr, cpu_wdata, cpu_rdata;
  logic       instr_start, cpu_en, cpu_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we, halted, bp_hit;
  logic [15:0] instr_count;

  always #10 CLOCK_50 = ~CLOCK_50;

  cpu_run_ctrl_if #(.AW(8), .DW(8)) dbg_bus ();

  cpu_run_ctrl #(.AW(8), .DW(8), .CW(16)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESETn      (RESETn),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc          (pc),
    .instr_start (instr_start),
    .cpu_en      (cpu_en),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_rdata   (cpu_rdata),
    .dbg         (dbg_bus.slave),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  // memory: combinational read, synchronous write, write counter
  logic [7:0] mem [256];
  int nwr = 0;
  assign mem_rdata = mem[mem_addr];
  always @(posedge CLOCK_50) if (mem_we) begin
    mem[mem_addr] <= mem_wdata;
    nwr <= nwr + 1;
  end

  // CPU model: cyc 0 = fetch (CYCLE1), 1, 2; opcode bit7 = STORE pc to 0x80|pc
  logic [1:0] cyc;
  logic [7:0] ir;
  assign instr_start = (cyc == 2'd0);
  assign cpu_addr    = (cyc == 2'd0) ? pc : {1'b1, pc[6:0]};
  assign cpu_we      = (cyc == 2'd2) && ir[7];
  assign cpu_wdata   = pc;
  always @(posedge CLOCK_50 or negedge RESETn) begin
    if (!RESETn) begin
      cyc <= 0; pc <= 0; ir <= 0;
    end else if (cpu_en) begin
      case (cyc)
        2'd0:    begin ir <= cpu_rdata; cyc <= 2'd1; end
        2'd1:    cyc <= 2'd2;
        default: begin cyc <= 2'd0; pc <= pc + 8'd1; end
      endcase
    end
  end

  int nchk = 0, npass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // scoreboard: expected dbg_rdata per access, popped on dbg_done
  logic [7:0] sb_q [$];
  logic [7:0] last_rd = 8'h00;
  always @(negedge CLOCK_50) if (dbg_bus.dbg_done === 1'b1) begin
    if (sb_q.size() == 0) chk("dbg_unexpected_done", 1, 0);
    else chk("dbg_rdata", dbg_bus.dbg_rdata, sb_q.pop_front());
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic dbg_start(input logic we, input logic [7:0] a, input logic [7:0] d, input bit push);
    dbg_bus.dbg_we = we; dbg_bus.dbg_addr = a; dbg_bus.dbg_wdata = d;
    dbg_bus.dbg_req = 1'b1;
    if (push) begin
      sb_q.push_back(we ? last_rd : d);
      if (!we) last_rd = d;
    end
  endtask

  task automatic dbg_wait(input int max, output int busy, output bit done);
    busy = 0; done = 0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      if (!halted) busy++;
      if (dbg_bus.dbg_done) done = 1;
    end
    dbg_bus.dbg_req = 1'b0;
    chk("dbg_timeout", done, 1);
  endtask

  // one debug access from HALTED; d is write data or expected read data
  task automatic dbg_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    int busy; bit done;
    dbg_start(we, a, d, 1);
    dbg_wait(20, busy, done);
    chk("dbg_cycles", busy, 1);
  endtask

  task automatic wait_halted(input int max);
    for (int i = 0; i < max && !halted; i++) tick();
    chk("halt_timeout", halted, 1);
  endtask

  initial begin
    int c0, w0, busy;
    logic [7:0] p0;
    bit done, seen;
    dbg_bus.dbg_req = 0; dbg_bus.dbg_we = 0; dbg_bus.dbg_addr = 0; dbg_bus.dbg_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1 RESETn = 1'b0;
    tick(2);
    chk("rst_halted", halted, 1);
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_bp_hit", bp_hit, 0);
    chk("rst_done", dbg_bus.dbg_done, 0);
    chk("rst_rdata", dbg_bus.dbg_rdata, 0);
    RESETn = 1'b1;
    tick();

    // run from PC 0 with a breakpoint at 05
    bp_en = 1; bp_addr = 8'h05; run_req = 1;
    tick();
    chk("run_halted", halted, 0);
    chk("run_cpu_en", cpu_en, 1);
    tick(12);
    chk("run_count4", instr_count, 4);
    wait_halted(40);
    run_req = 0;
    chk("bp_pc", pc, 8'h05);
    chk("bp_hit", bp_hit, 1);
    chk("bp_count", instr_count, 5);
    tick(2);
    chk("bp_frozen_pc", pc, 8'h05);
    chk("bp_frozen_cyc", cyc, 0);

    // debug write then read while halted; DBG must not clear bp_hit
    dbg_access(1'b1, 8'h10, 8'hA5);
    dbg_access(1'b0, 8'h10, 8'hA5);
    chk("dbg_mem_wr", mem[8'h10], 8'hA5);
    chk("bp_hit_kept", bp_hit, 1);

    // resume at the breakpoint address: no re-hit
    run_req = 1;
    tick();
    chk("resume_halted", halted, 0);
    chk("resume_bp_clr", bp_hit, 0);
    chk("resume_cpu_en", cpu_en, 1);
    bp_en = 0;
    tick(3);
    chk("resume_pc", pc, 8'h06);

    // halt_req mid-instruction waits for the next boundary
    for (int i = 0; i < 10 && cyc != 2'd1; i++) tick();
    halt_req = 1; tick(); halt_req = 0;
    chk("halt_mid_en", cpu_en, 1);
    tick();
    chk("halt_bnd_en", cpu_en, 0);
    chk("halt_bnd_state", halted, 0);
    tick();
    chk("halt_halted", halted, 1);
    run_req = 0;
    c0 = instr_count; p0 = pc;
    tick(3);
    chk("halt_frozen_cnt", instr_count, c0);
    chk("halt_frozen_pc", pc, p0);
    chk("halt_frozen_cyc", cyc, 0);

    // single step a STORE placed at the current pc
    dbg_access(1'b1, p0, 8'h80);
    w0 = nwr; c0 = instr_count;
    step_req = 1; tick(); step_req = 0;
    chk("step_active", halted, 0);
    wait_halted(20);
    chk("step_count", instr_count, c0 + 1);
    chk("step_pc", pc, p0 + 8'd1);
    chk("step_writes", nwr, w0 + 1);
    dbg_access(1'b0, {1'b1, p0[6:0]}, p0);

    // debug request during RUN is held off until the CPU halts
    run_req = 1; tick();
    dbg_start(1'b1, 8'h20, 8'h3C, 1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dbg_bus.dbg_done || halted) seen = 1;
    end
    chk("dbg_held", seen, 0);
    chk("dbg_held_mem", mem[8'h20], 0);
    halt_req = 1; run_req = 0; tick(); halt_req = 0;
    dbg_wait(30, busy, done);
    chk("dbg_late_mem", mem[8'h20], 8'h3C);

    // asynchronous reset in the middle of a DBG cycle
    tick();
    dbg_start(1'b0, 8'h10, 8'h00, 0);
    tick();
    chk("dbg_state", halted, 0);
    RESETn = 1'b0; dbg_bus.dbg_req = 1'b0;
    #1;
    chk("arst_halted", halted, 1);
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_done", dbg_bus.dbg_done, 0);
    chk("arst_rdata", dbg_bus.dbg_rdata, 0);
    chk("arst_count", instr_count, 0);
    chk("arst_bp_hit", bp_hit, 0);
    chk("arst_mem_we", mem_we, 0);
    #5 RESETn = 1'b1;
    tick(2);
    chk("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
